// File: rtl/capture_pkg.sv
// Shared types and default sizes for the capture sequencer.
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ARMED,
        POST,
        DONE
    } cap_state_t;

    localparam int DEFAULT_ADDR_W  = 9;
    localparam int DEFAULT_DECIM_W = 4;

endpackage

// File: rtl/decim_tick_gen.sv
// Sample-tick generator: one tick every 2**decimator clocks while run is high.
module decim_tick_gen
    import capture_pkg::*;
#(
    parameter int DECIM_W = DEFAULT_DECIM_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [DECIM_W-1:0] decimator,
    output logic               tick
);

    localparam int CNT_W = 2 ** DECIM_W;

    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   limit;
    logic [DECIM_W-1:0] dec_q;

    assign limit = (CNT_W'(1) << dec_q) - CNT_W'(1);
    assign tick  = run && (cnt == limit);

    // Count clocks while running; the exponent is only re-latched at a wrap or while stopped,
    // so a mid-capture change of decimator never truncates the period in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            dec_q <= '0;
        end else if (!run || tick) begin
            cnt   <= '0;
            dec_q <= decimator;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: fills the circular capture RAM, arms the trigger once enough
// pre-trigger history is stored, then records trig_pos post-trigger samples.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DECIM_W = DEFAULT_DECIM_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cap_en,
    input  logic [ADDR_W-1:0]  trig_pos,
    input  logic [DECIM_W-1:0] decimator,
    input  logic               triggered,
    input  logic               cap_done_clr,
    output logic               armed,
    output logic               set_cap_done,
    output logic               capture_done,
    output logic               we,
    output logic [ADDR_W-1:0]  waddr,
    output logic [ADDR_W-1:0]  trig_addr
);

    localparam int ENTRIES = 2 ** ADDR_W;
    localparam int CNT_W   = ADDR_W + 1;

    cap_state_t        state;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  wr_next;
    logic [CNT_W-1:0]  post_cnt;
    logic [CNT_W-1:0]  pre_cnt;
    logic [ADDR_W-1:0] trig_pos_q;
    logic [ADDR_W-1:0] trig_pos_clamped;
    logic              run;
    logic              tick;
    logic              post_full;

    assign run = (state == FILL) || (state == ARMED) || (state == POST);

    decim_tick_gen #(
        .DECIM_W(DECIM_W)
    ) u_tick (
        .clk(clk),
        .rst(rst),
        .run(run),
        .decimator(decimator),
        .tick(tick)
    );

    // A full ring of pre-trigger history would leave no room after the trigger,
    // so the post count is limited to ENTRIES-1 and at least one pre sample remains.
    assign trig_pos_clamped = (trig_pos >= ADDR_W'(ENTRIES - 1)) ? ADDR_W'(ENTRIES - 1) : trig_pos;
    assign pre_cnt          = CNT_W'(ENTRIES) - {1'b0, trig_pos_q};
    assign wr_next          = wr_cnt + CNT_W'(1);

    // The sample written in the cycle the trigger is seen already counts as post-trigger,
    // so once the post count is reached no further write may happen.
    assign post_full    = (state == POST) && (post_cnt >= {1'b0, trig_pos_q});
    assign we           = tick && !post_full;
    assign set_cap_done = post_full && cap_en;

    // Main sequencer: state, write address, counters and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_cnt       <= '0;
            post_cnt     <= '0;
            trig_pos_q   <= '0;
            waddr        <= '0;
            trig_addr    <= '0;
            armed        <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            if (we) begin
                waddr <= waddr + ADDR_W'(1);
            end
            if (cap_done_clr) begin
                capture_done <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (cap_en && !capture_done) begin
                        state      <= FILL;
                        wr_cnt     <= '0;
                        trig_pos_q <= trig_pos_clamped;
                    end
                end
                FILL: begin
                    if (!cap_en) begin
                        state <= IDLE;
                    end else if (we) begin
                        wr_cnt <= wr_next;
                        if (wr_next == pre_cnt) begin
                            state <= ARMED;
                            armed <= 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (!cap_en) begin
                        state <= IDLE;
                        armed <= 1'b0;
                    end else if (triggered) begin
                        state     <= POST;
                        armed     <= 1'b0;
                        trig_addr <= waddr;
                        post_cnt  <= we ? CNT_W'(1) : '0;
                    end
                end
                POST: begin
                    if (!cap_en) begin
                        state <= IDLE;
                    end else if (post_full) begin
                        state        <= DONE;
                        capture_done <= 1'b1;
                    end else if (we) begin
                        post_cnt <= post_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (cap_done_clr) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: directed and randomized captures compared cycle by cycle
// against an arithmetic model of the sample timeline.
module tb_capture_ctrl;

    localparam int ADDR_W  = 4;
    localparam int DECIM_W = 4;
    localparam int ENTRIES = 2 ** ADDR_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               cap_en;
    logic [ADDR_W-1:0]  trig_pos;
    logic [DECIM_W-1:0] decimator;
    logic               triggered;
    logic               cap_done_clr;
    logic               armed;
    logic               set_cap_done;
    logic               capture_done;
    logic               we;
    logic [ADDR_W-1:0]  waddr;
    logic [ADDR_W-1:0]  trig_addr;

    int checks     = 0;
    int errors     = 0;
    int start_addr = 0;

    always #5 clk = ~clk;

    capture_ctrl #(
        .ADDR_W(ADDR_W),
        .DECIM_W(DECIM_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cap_en(cap_en),
        .trig_pos(trig_pos),
        .decimator(decimator),
        .triggered(triggered),
        .cap_done_clr(cap_done_clr),
        .armed(armed),
        .set_cap_done(set_cap_done),
        .capture_done(capture_done),
        .we(we),
        .waddr(waddr),
        .trig_addr(trig_addr)
    );

    // One comparison: counts it and reports tag, observed and expected on a miss.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive the control inputs for the cycle that starts at the next rising edge.
    task automatic applyStimulus(input logic en, input logic trig, input logic clr);
        @(posedge clk);
        #1;
        cap_en       = en;
        triggered    = trig;
        cap_done_clr = clr;
    endtask

    // Full capture from IDLE. Writes fall on FILL-relative cycles k*period-1; armed holds
    // from the pre-th write until the trigger cycle; done follows the trig_pos-th write at or
    // after the trigger cycle (or the cycle after the trigger when trig_pos is 0).
    task automatic runCapture(input int d, input int p, input int rel, input bit early, input bit clr_at_done);
        int period, pc, a, t, first_post, dcyc, total;
        period     = 1 << d;
        pc         = (p >= ENTRIES - 1) ? ENTRIES - 1 : p;
        a          = (ENTRIES - pc) * period;
        t          = early ? a : a + rel;
        first_post = (t + period) / period;
        if (pc == 0) begin
            dcyc  = t + 1;
            total = (t + 1) / period;
        end else begin
            dcyc  = (first_post + pc - 1) * period;
            total = first_post + pc - 1;
        end
        @(posedge clk);
        #1;
        decimator    = DECIM_W'(d);
        trig_pos     = ADDR_W'(p);
        cap_en       = 1'b1;
        triggered    = early;
        cap_done_clr = 1'b0;
        for (int c = 0; c <= dcyc; c++) begin
            applyStimulus(1'b1, early || (c >= t), clr_at_done && (c == dcyc));
            @(negedge clk);
            checkOutput($sformatf("we d=%0d p=%0d c=%0d", d, p, c), we, ((c + 1) % period == 0) && (c < dcyc));
            checkOutput($sformatf("armed d=%0d p=%0d c=%0d", d, p, c), armed, (c >= a) && (c <= t));
            checkOutput($sformatf("set_cap_done d=%0d p=%0d c=%0d", d, p, c), set_cap_done, c == dcyc);
            checkOutput($sformatf("waddr d=%0d p=%0d c=%0d", d, p, c), waddr, (start_addr + c / period) % ENTRIES);
            checkOutput($sformatf("capture_done d=%0d p=%0d c=%0d", d, p, c), capture_done, 0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("done capture_done", capture_done, 1);
        checkOutput("done we", we, 0);
        checkOutput("done set_cap_done", set_cap_done, 0);
        checkOutput("done armed", armed, 0);
        checkOutput("done waddr", waddr, (start_addr + total) % ENTRIES);
        checkOutput("done trig_addr", trig_addr, (start_addr + first_post - 1) % ENTRIES);
        start_addr = (start_addr + total) % ENTRIES;
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("cleared capture_done", capture_done, 0);
        checkOutput("cleared we", we, 0);
        checkOutput("cleared waddr", waddr, start_addr);
    endtask

    // Directed scenarios first, then randomized captures, then a reset during ARMED.
    initial begin
        rst          = 1'b1;
        cap_en       = 1'b0;
        triggered    = 1'b0;
        cap_done_clr = 1'b0;
        trig_pos     = '0;
        decimator    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset armed", armed, 0);
        checkOutput("reset set_cap_done", set_cap_done, 0);
        checkOutput("reset capture_done", capture_done, 0);
        checkOutput("reset we", we, 0);
        checkOutput("reset waddr", waddr, 0);
        checkOutput("reset trig_addr", trig_addr, 0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        start_addr = 0;

        $display("[TB] directed captures");
        runCapture(0, 4, 9, 1'b0, 1'b0);
        runCapture(2, 5, 7, 1'b0, 1'b0);
        runCapture(0, 0, 3, 1'b0, 1'b0);
        runCapture(1, 0, 0, 1'b1, 1'b0);
        runCapture(0, 15, 4, 1'b0, 1'b0);
        runCapture(1, 6, 2, 1'b1, 1'b1);

        $display("[TB] abort in POST and restart");
        @(posedge clk);
        #1;
        decimator = '0;
        trig_pos  = ADDR_W'(8);
        cap_en    = 1'b1;
        triggered = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            applyStimulus(c < 10, c >= 8, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("abort set_cap_done c=%0d", c), set_cap_done, 0);
            checkOutput($sformatf("abort armed c=%0d", c), armed, c == 8);
        end
        applyStimulus(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("abort idle armed", armed, 0);
        checkOutput("abort idle we", we, 0);
        checkOutput("abort idle capture_done", capture_done, 0);
        checkOutput("abort idle waddr", waddr, (start_addr + 11) % ENTRIES);
        checkOutput("abort trig_addr", trig_addr, (start_addr + 8) % ENTRIES);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("restart we", we, 1);
        checkOutput("restart armed", armed, 0);
        checkOutput("restart waddr", waddr, (start_addr + 11) % ENTRIES);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("restart abort we", we, 0);
        checkOutput("restart abort waddr", waddr, (start_addr + 12) % ENTRIES);
        start_addr = (start_addr + 12) % ENTRIES;

        $display("[TB] randomized captures");
        for (int r = 0; r < 12; r++) begin
            runCapture(int'($urandom_range(0, 2)), int'($urandom_range(0, 15)), int'($urandom_range(0, 20)),
                       $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        $display("[TB] reset while ARMED with trigger");
        @(posedge clk);
        #1;
        decimator = '0;
        trig_pos  = ADDR_W'(4);
        cap_en    = 1'b1;
        triggered = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        checkOutput("pre-reset armed", armed, 1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst armed", armed, 0);
        checkOutput("rst we", we, 0);
        checkOutput("rst set_cap_done", set_cap_done, 0);
        checkOutput("rst capture_done", capture_done, 0);
        checkOutput("rst waddr", waddr, 0);
        checkOutput("rst trig_addr", trig_addr, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        cap_en    = 1'b0;
        triggered = 1'b0;
        @(negedge clk);
        checkOutput("post-rst armed", armed, 0);
        checkOutput("post-rst we", we, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
